// File: rtl/ngc_counter_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// ngc_counter_ctrl_pkg : command opcodes and FSM states for the timer. Rev 1.0
// ----------------------------------------------------------------------
package ngc_counter_ctrl_pkg;

  typedef enum logic [1:0] {
    NOP   = 2'b00,
    START = 2'b01,
    STOP  = 2'b10,
    RSVD  = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ARM    = 3'd2,
    RUN    = 3'd3,
    FINISH = 3'd4
  } state_e;

endpackage : ngc_counter_ctrl_pkg
`default_nettype wire

// File: rtl/ngc_counter.sv
`default_nettype none
// ----------------------------------------------------------------------
// ngc_counter : free up/down counter with from/to window and one-shot hold. Rev 1.0
// ----------------------------------------------------------------------
module ngc_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enb,
  input  logic             dir,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] step_value,
  input  logic [WIDTH-1:0] count_from_value,
  input  logic [WIDTH-1:0] count_to_value,
  output logic [WIDTH-1:0] count,
  output logic             count_hit
);

  logic [WIDTH-1:0] from_q;
  logic [WIDTH-1:0] to_q;

  // rst restarts the window: count takes count_from and both limits are captured
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= count_from_value;
      from_q <= count_from_value;
      to_q   <= count_to_value;
    end else if (load) begin
      count <= load_value;
    end else if (enb) begin
      if (count == to_q) begin
        if (!one_shot) count <= from_q;
      end else if (dir) begin
        count <= count - step_value;
      end else begin
        count <= count + step_value;
      end
    end
  end

  assign count_hit = (count == to_q);

endmodule : ngc_counter
`default_nettype wire

// File: rtl/ngc_counter_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// ngc_counter_ctrl : command-driven N-shot periodic timer for ngc_counter.
// Defining NGC_COUNTER_CTRL_PAUSE_EN adds a pause input.  Rev 1.0
// ----------------------------------------------------------------------
module ngc_counter_ctrl
  import ngc_counter_ctrl_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int REP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef NGC_COUNTER_CTRL_PAUSE_EN
  input  logic                 pause,
`endif
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_from,
  input  logic [WIDTH-1:0]     cmd_to,
  input  logic [WIDTH-1:0]     cmd_step,
  input  logic                 cmd_dir,
  input  logic [REP_WIDTH-1:0] cmd_repeat,
  output logic                 busy,
  output logic                 done,
  output logic [REP_WIDTH-1:0] hits,
  output logic                 cnt_rst,
  output logic                 cnt_load,
  output logic                 cnt_enb,
  output logic                 cnt_dir,
  output logic                 cnt_one_shot,
  output logic [WIDTH-1:0]     cnt_load_value,
  output logic [WIDTH-1:0]     cnt_step_value,
  output logic [WIDTH-1:0]     cnt_count_from_value,
  output logic [WIDTH-1:0]     cnt_count_to_value,
  input  logic [WIDTH-1:0]     cnt_count,
  input  logic                 cnt_count_hit
);

  localparam logic [REP_WIDTH-1:0] REP_ONE = {{(REP_WIDTH-1){1'b0}}, 1'b1};

  state_e               state;
  state_e               state_nxt;
  logic [REP_WIDTH-1:0] rep;
  logic [REP_WIDTH-1:0] hits_nxt;
  logic                 latch;
  logic                 accept;
  logic                 op_start;
  logic                 op_stop;
  logic                 paused;
  logic                 hit;
  logic                 last_hit;
  logic                 one_shot_nxt;
  logic                 unused_cnt_count;

`ifdef NGC_COUNTER_CTRL_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign accept   = cmd_valid && cmd_ready;
  assign op_start = accept && (cmd_op == START);
  assign op_stop  = accept && (cmd_op == STOP);
  assign hit      = cnt_count_hit && !paused;
  assign last_hit = (rep != '0) && (hits == rep - REP_ONE);

  // count value is status only; nothing in the sequencing depends on it
  assign unused_cnt_count = ^cnt_count;

  always_comb begin
    state_nxt = state;
    hits_nxt  = hits;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (op_start) begin
          state_nxt = SETUP;
          hits_nxt  = '0;
          latch     = 1'b1;
        end
      end
      SETUP: state_nxt = ARM;
      ARM:   state_nxt = RUN;
      RUN: begin
        // a restart discards a coincident hit, a stop still counts it
        if (op_start) begin
          state_nxt = SETUP;
          hits_nxt  = '0;
          latch     = 1'b1;
        end else if (op_stop) begin
          state_nxt = FINISH;
          if (hit) hits_nxt = hits + REP_ONE;
        end else if (hit) begin
          hits_nxt = hits + REP_ONE;
          if (last_hit) state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // the counter must freeze at count_to on the final hit, so one_shot is
  // raised while the next hit would be the last one
  assign one_shot_nxt = (state_nxt == RUN) && (rep != '0) &&
                        (hits_nxt == rep - REP_ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      rep                  <= '0;
      hits                 <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      cmd_ready            <= 1'b0;
      cnt_rst              <= 1'b1;
      cnt_load             <= 1'b0;
      cnt_enb              <= 1'b0;
      cnt_dir              <= 1'b0;
      cnt_one_shot         <= 1'b0;
      cnt_load_value       <= '0;
      cnt_step_value       <= '0;
      cnt_count_from_value <= '0;
      cnt_count_to_value   <= '0;
    end else begin
      state          <= state_nxt;
      hits           <= hits_nxt;
      busy           <= (state_nxt != IDLE);
      done           <= (state_nxt == FINISH);
      cmd_ready      <= (state_nxt == IDLE) || (state_nxt == RUN);
      cnt_rst        <= (state_nxt == SETUP);
      cnt_load       <= 1'b0;
      cnt_load_value <= '0;
      cnt_enb        <= (state_nxt == RUN) && !paused;
      cnt_one_shot   <= one_shot_nxt;
      if (latch) begin
        rep                  <= cmd_repeat;
        cnt_dir              <= cmd_dir;
        cnt_step_value       <= cmd_step;
        cnt_count_from_value <= cmd_from;
        cnt_count_to_value   <= cmd_to;
      end
    end
  end

endmodule : ngc_counter_ctrl
`default_nettype wire
